// File: rtl/ddr_burst_memory.sv
// ddr_burst_memory: burst command/data memory model with strobed writes, read latency and error response
module ddr_burst_memory #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_SIZE = 16,
  parameter int LEN_WIDTH = 4,
  parameter int RD_LATENCY = 2,
  localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_wr,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  wdata_valid,
  output logic                  wdata_ready,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [STRB_WIDTH-1:0] wstrb,
  output logic                  rdata_valid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rdata_last,
  output logic                  resp_valid,
  output logic                  resp_err
);
  localparam int LW = RD_LATENCY > 2 ? $clog2(RD_LATENCY - 1) : 1;
  localparam logic [ADDR_WIDTH-1:0] TOP = ADDR_WIDTH'(MEM_SIZE - 1);
  typedef enum logic [2:0] {IDLE, WRITE, WRESP, RWAIT, READ} state_t;
  state_t state;
  logic [DATA_WIDTH-1:0] mem [MEM_SIZE];
  logic [ADDR_WIDTH-1:0] ptr, nxt;
  logic [LEN_WIDTH-1:0] len, cnt;
  logic [LW-1:0] wcnt;
  logic err, last;
  assign nxt = ptr == TOP ? '0 : ptr + ADDR_WIDTH'(1);
  assign last = cnt == len;
  assign cmd_ready = state == IDLE;
  assign wdata_ready = state == WRITE;
  assign rdata_valid = state == READ;
  assign rdata = (state == READ && !err) ? mem[ptr] : '0;
  assign rdata_last = state == READ && last;
  assign resp_valid = state == WRESP || (state == READ && last);
  assign resp_err = resp_valid && err;
  // Burst sequencing: latch the command, walk the wrapping word pointer, count beats and read latency
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      ptr <= '0;
      len <= '0;
      cnt <= '0;
      wcnt <= '0;
      err <= 1'b0;
    end else
      case (state)
        IDLE: if (cmd_valid) begin
          ptr <= cmd_addr;
          len <= cmd_len;
          cnt <= '0;
          wcnt <= '0;
          err <= {1'b0, cmd_addr} >= (ADDR_WIDTH + 1)'(MEM_SIZE);
          state <= cmd_wr ? WRITE : (RD_LATENCY == 1 ? READ : RWAIT);
        end
        WRITE: if (wdata_valid) begin
          ptr <= nxt;
          cnt <= cnt + LEN_WIDTH'(1);
          state <= last ? WRESP : WRITE;
        end
        WRESP: state <= IDLE;
        RWAIT: begin
          wcnt <= wcnt + LW'(1);
          state <= wcnt == LW'(RD_LATENCY - 2) ? READ : RWAIT;
        end
        READ: begin
          ptr <= nxt;
          cnt <= cnt + LEN_WIDTH'(1);
          state <= last ? IDLE : READ;
        end
        default: state <= IDLE;
      endcase
  // Storage: cleared on reset, byte-strobed update on each accepted in-range write beat
  always_ff @(posedge clk)
    if (reset)
      for (int i = 0; i < MEM_SIZE; i++) mem[i] <= '0;
    else if (state == WRITE && wdata_valid && !err)
      for (int i = 0; i < STRB_WIDTH; i++)
        if (wstrb[i]) mem[ptr][8*i +: 8] <= wdata[8*i +: 8];
endmodule

// File: tb/tb_ddr_burst_memory.sv
// tb_ddr_burst_memory: directed and randomized bursts checked every cycle against a timeline model
module tb_ddr_burst_memory;
  localparam int MS = 12;
  localparam int L = 3;
  localparam int NCYC = 40000;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready, cmd_wr = 1'b0;
  logic [3:0] cmd_addr = '0, cmd_len = '0;
  logic wdata_valid = 1'b0, wdata_ready;
  logic [31:0] wdata = '0;
  logic [3:0] wstrb = '0;
  logic rdata_valid, rdata_last, resp_valid, resp_err;
  logic [31:0] rdata;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  bit exp_busy [NCYC];
  bit exp_wr [NCYC];
  bit exp_rv [NCYC];
  bit exp_last [NCYC];
  bit exp_resp [NCYC];
  bit exp_err [NCYC];
  logic [31:0] exp_rd [NCYC];
  logic [31:0] mem_m [MS];
  logic [31:0] wbuf [16];
  logic [3:0] wsb [16];
  logic [31:0] rd_log [$];
  int rd_cyc [$];

  ddr_burst_memory #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .MEM_SIZE(MS), .LEN_WIDTH(4), .RD_LATENCY(L)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
    .wdata(wdata), .wstrb(wstrb), .rdata_valid(rdata_valid), .rdata(rdata), .rdata_last(rdata_last),
    .resp_valid(resp_valid), .resp_err(resp_err));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] g, input logic [31:0] e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s cycle %0d got %h expected %h", n, cyc, g, e);
    end
  endtask

  // every cycle: outputs against the timeline the driver scheduled
  always @(negedge clk)
    if (chk_en && cyc < NCYC) begin
      chk("cmd_ready", 32'(cmd_ready), 32'(!exp_busy[cyc]));
      chk("wdata_ready", 32'(wdata_ready), 32'(exp_wr[cyc]));
      chk("rdata_valid", 32'(rdata_valid), 32'(exp_rv[cyc]));
      chk("rdata", rdata, exp_rv[cyc] ? exp_rd[cyc] : 32'h0);
      chk("rdata_last", 32'(rdata_last), 32'(exp_last[cyc]));
      chk("resp_valid", 32'(resp_valid), 32'(exp_resp[cyc]));
      if (exp_resp[cyc]) chk("resp_err", 32'(resp_err), 32'(exp_err[cyc]));
      if (rdata_valid) begin
        rd_log.push_back(rdata);
        rd_cyc.push_back(cyc);
      end
    end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic junk();
    wdata_valid = 1'($urandom);
    wdata = $urandom;
    wstrb = 4'($urandom);
  endtask

  task automatic lit(input string n, input int i, input logic [31:0] v);
    chk(n, i < rd_log.size() ? rd_log[i] : 32'hxxxxxxxx, v);
  endtask

  task automatic do_write(input int a, input int n, input int gmax);
    bit e = a >= MS;
    cmd_valid = 1'b1;
    cmd_wr = 1'b1;
    cmd_addr = 4'(a);
    cmd_len = 4'(n);
    junk();
    for (int j = 0; j <= n; j++) begin
      step();
      cmd_valid = 1'b0;
      repeat ($urandom_range(0, gmax)) begin
        wdata_valid = 1'b0;
        exp_busy[cyc] = 1'b1;
        exp_wr[cyc] = 1'b1;
        step();
      end
      wdata_valid = 1'b1;
      wdata = wbuf[j];
      wstrb = wsb[j];
      exp_busy[cyc] = 1'b1;
      exp_wr[cyc] = 1'b1;
      if (!e)
        for (int b = 0; b < 4; b++)
          if (wsb[j][b]) mem_m[(a + j) % MS][8*b +: 8] = wbuf[j][8*b +: 8];
    end
    step();
    junk();
    exp_busy[cyc] = 1'b1;
    exp_resp[cyc] = 1'b1;
    exp_err[cyc] = e;
    step();
    junk();
  endtask

  task automatic do_read(input int a, input int n);
    bit e = a >= MS;
    int c;
    rd_log.delete();
    rd_cyc.delete();
    cmd_valid = 1'b1;
    cmd_wr = 1'b0;
    cmd_addr = 4'(a);
    cmd_len = 4'(n);
    junk();
    for (int i = 0; i <= n; i++) begin
      c = cyc + L + i;
      exp_rv[c] = 1'b1;
      exp_rd[c] = e ? 32'h0 : mem_m[(a + i) % MS];
      exp_last[c] = i == n;
      exp_resp[c] = i == n;
      exp_err[c] = e;
    end
    for (int k = 1; k <= L + n; k++) exp_busy[cyc + k] = 1'b1;
    step();
    cmd_valid = 1'b0;
    junk();
    repeat (L + n - 1) begin
      step();
      junk();
    end
    step();
    junk();
  endtask

  task automatic fill(input int n, input logic [31:0] base, input logic [3:0] s);
    for (int j = 0; j < 16; j++) begin
      wbuf[j] = base + 32'(j);
      wsb[j] = s;
    end
  endtask

  initial begin
    int a0;
    for (int i = 0; i < MS; i++) mem_m[i] = '0;
    repeat (3) step();
    reset = 1'b0;
    chk_en = 1'b1;
    a0 = cyc;
    do_read(0, 0);
    chk("rst_read_cnt", 32'(rd_log.size()), 32'd1);
    lit("rst_read_data", 0, 32'h0);
    chk("rst_read_lat", 32'(rd_cyc.size() > 0 ? rd_cyc[0] - a0 : -1), 32'd3);
    fill(3, 32'hA0, 4'hF);
    do_write(3, 3, 0);
    do_read(3, 3);
    lit("burst0", 0, 32'hA0);
    lit("burst3", 3, 32'hA3);
    fill(3, 32'hB0, 4'hF);
    do_write(10, 3, 2);
    do_read(10, 3);
    lit("wrap10", 0, 32'hB0);
    lit("wrap11", 1, 32'hB1);
    lit("wrap0", 2, 32'hB2);
    lit("wrap1", 3, 32'hB3);
    fill(0, 32'hFFFFFFFF, 4'hF);
    do_write(5, 0, 0);
    fill(0, 32'h12345678, 4'b0101);
    do_write(5, 0, 1);
    do_read(5, 0);
    lit("strobe", 0, 32'hFF34FF78);
    fill(1, 32'hC0, 4'hF);
    do_write(13, 1, 1);
    do_read(13, 0);
    lit("err_read", 0, 32'h0);
    do_read(0, 11);
    lit("after_err0", 0, 32'hB2);
    lit("after_err5", 5, 32'hFF34FF78);
    fill(3, 32'hD0, 4'h0);
    do_write(4, 3, 0);
    do_read(3, 1);
    lit("zero_strb", 1, 32'hA1);
    cmd_valid = 1'b1;
    cmd_wr = 1'b1;
    cmd_addr = 4'd2;
    cmd_len = 4'd3;
    step();
    cmd_valid = 1'b0;
    wdata_valid = 1'b1;
    wdata = 32'hDEADBEEF;
    wstrb = 4'hF;
    exp_busy[cyc] = 1'b1;
    exp_wr[cyc] = 1'b1;
    step();
    wdata = 32'hCAFEF00D;
    exp_busy[cyc] = 1'b1;
    exp_wr[cyc] = 1'b1;
    reset = 1'b1;
    step();
    reset = 1'b0;
    junk();
    for (int i = 0; i < MS; i++) mem_m[i] = '0;
    chk("rst_mid_ready", 32'(cmd_ready), 32'd1);
    do_read(0, 15);
    lit("rst_mid_w2", 2, 32'h0);
    lit("rst_mid_w3", 3, 32'h0);
    for (int it = 0; it < 150; it++) begin
      int a = $urandom_range(0, 15);
      int n = $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) begin
        for (int j = 0; j < 16; j++) begin
          wbuf[j] = $urandom;
          wsb[j] = 4'($urandom);
        end
        do_write(a, n, $urandom_range(0, 2));
      end else
        do_read(a, n);
      repeat ($urandom_range(0, 1)) begin
        step();
        junk();
      end
    end
    do_read(0, 11);
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
